// File: rtl/ln_pkg.sv
// ln_pkg: constants and result type shared by the LayerNorm stages.
//   N_PARTS/N_BANKS  : beats per token / independent bank pointers
//   PSUM_W/PSQ_W     : stage-1 partial widths (signed)
//   SUM_W/SQ_W       : token total widths (signed)
//   MEAN_W/VAR_W     : Q15.8 mean, Q31.8 variance
//   RECIP_K/RECIP_SH : multiply-and-shift replacement for /768 at Q.8
package ln_pkg;

  localparam int N_PARTS  = 12;
  localparam int N_BANKS  = 4;
  localparam int PSUM_W   = 22;
  localparam int PSQ_W    = 38;
  localparam int SUM_W    = 26;
  localparam int SQ_W     = 42;
  localparam int FRAC     = 8;
  localparam int MEAN_W   = 24;
  localparam int VAR_W    = 40;
  localparam int PTR_W    = 2;
  localparam int CNT_W    = 4;
  localparam int RECIP_SH = 24;

  // ceil(2^24/3): 256/768 reduces to 1/3
  localparam logic [22:0] RECIP_K = 23'd5592406;

  typedef struct packed {
    logic [PTR_W-1:0]         ptr;
    logic signed [SUM_W-1:0]  sum;
    logic signed [MEAN_W-1:0] mean;
    logic [VAR_W-1:0]         variance;
  } stat_t;

endpackage

// File: rtl/ln_stage2_finalize.sv
// ln_stage2_finalize: 4-stage mean / variance pipe.
//   i_clk, i_rst (sync, active-low), i_en (stall: everything holds)
//   i_valid/i_ptr/i_sum/i_sq : completed token totals
//   o_valid                  : one-cycle result pulse
//   o_stat                   : ptr, sum, mean (Q15.8), variance (Q31.8); held between pulses
module ln_stage2_finalize
  import ln_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_valid,
  input  logic [PTR_W-1:0]        i_ptr,
  input  logic signed [SUM_W-1:0] i_sum,
  input  logic signed [SQ_W-1:0]  i_sq,
  output logic                    o_valid,
  output stat_t                   o_stat
);

  localparam int MPROD_W = SUM_W + 24;
  localparam int QPROD_W = SQ_W + 25;
  localparam int MSQP_W  = 2 * MEAN_W;

  // F1
  logic                     r_v1;
  logic [PTR_W-1:0]         r_ptr1;
  logic signed [SUM_W-1:0]  r_s1;
  logic signed [SQ_W-1:0]   r_q1;
  // F2
  logic                     r_v2;
  logic [PTR_W-1:0]         r_ptr2;
  logic signed [SUM_W-1:0]  r_s2;
  logic signed [MEAN_W-1:0] r_mean2;
  logic signed [SQ_W-1:0]   r_ex2_2;
  // F3
  logic                     r_v3;
  logic [PTR_W-1:0]         r_ptr3;
  logic signed [SUM_W-1:0]  r_s3;
  logic signed [MEAN_W-1:0] r_mean3;
  logic signed [SQ_W-1:0]   r_ex2_3;
  logic signed [SQ_W-1:0]   r_msq3;
  // F4
  logic                     r_v4;
  stat_t                    r_out;

  // Mean is formed on |S| so the shift truncates toward zero, then re-signed.
  logic                       w_s_neg;
  logic [SUM_W-1:0]           w_s_abs;
  logic [MPROD_W-1:0]         w_abs_prod;
  logic [MEAN_W-1:0]          w_mean_mag;
  logic signed [MEAN_W-1:0]   w_mean;
  logic signed [QPROD_W-1:0]  w_sq_prod;
  logic signed [SQ_W-1:0]     w_ex2;
  logic signed [MSQP_W-1:0]   w_msq_prod;
  logic signed [SQ_W-1:0]     w_msq;
  logic signed [SQ_W:0]       w_diff;
  logic [VAR_W-1:0]           w_var;

  assign w_s_neg    = r_s1[SUM_W-1];
  assign w_s_abs    = w_s_neg ? SUM_W'(-r_s1) : r_s1;
  assign w_abs_prod = MPROD_W'(w_s_abs) * MPROD_W'(RECIP_K);
  assign w_mean_mag = MEAN_W'(w_abs_prod >> RECIP_SH);
  assign w_mean     = w_s_neg ? -$signed(w_mean_mag) : $signed(w_mean_mag);

  assign w_sq_prod  = QPROD_W'(r_q1) * QPROD_W'($signed({1'b0, RECIP_K}));
  assign w_ex2      = SQ_W'(w_sq_prod >>> RECIP_SH);

  assign w_msq_prod = MSQP_W'(r_mean2) * MSQP_W'(r_mean2);
  assign w_msq      = SQ_W'(w_msq_prod >>> FRAC);

  // Rounding in ex2 and msq can make the difference slightly negative.
  assign w_diff     = (SQ_W+1)'(r_ex2_3) - (SQ_W+1)'(r_msq3);
  assign w_var      = w_diff[SQ_W] ? '0 : VAR_W'(w_diff);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_v1    <= 1'b0;
      r_ptr1  <= '0;
      r_s1    <= '0;
      r_q1    <= '0;
      r_v2    <= 1'b0;
      r_ptr2  <= '0;
      r_s2    <= '0;
      r_mean2 <= '0;
      r_ex2_2 <= '0;
      r_v3    <= 1'b0;
      r_ptr3  <= '0;
      r_s3    <= '0;
      r_mean3 <= '0;
      r_ex2_3 <= '0;
      r_msq3  <= '0;
      r_v4    <= 1'b0;
      r_out   <= '0;
    end else if (i_en) begin
      r_v1 <= i_valid;
      if (i_valid) begin
        r_ptr1 <= i_ptr;
        r_s1   <= i_sum;
        r_q1   <= i_sq;
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_ptr2  <= r_ptr1;
        r_s2    <= r_s1;
        r_mean2 <= w_mean;
        r_ex2_2 <= w_ex2;
      end
      r_v3 <= r_v2;
      if (r_v2) begin
        r_ptr3  <= r_ptr2;
        r_s3    <= r_s2;
        r_mean3 <= r_mean2;
        r_ex2_3 <= r_ex2_2;
        r_msq3  <= w_msq;
      end
      r_v4 <= r_v3;
      if (r_v3) begin
        r_out.ptr      <= r_ptr3;
        r_out.sum      <= r_s3;
        r_out.mean     <= r_mean3;
        r_out.variance <= w_var;
      end
    end
  end

  assign o_valid = r_v4;
  assign o_stat  = r_out;

endmodule

// File: rtl/ln_stage2_reduce.sv
// ln_stage2_reduce: per-bank accumulation of stage-1 partials with sequence
// checking, feeding the mean/variance finalize pipe.
//   i_clk, i_rst (sync, active-low), i_en (global stall)
//   i_acc_valid/i_acc_ptr/i_acc_cnt/i_part_sum/i_part_sq_sum : partial beats
//   o_stat_valid/o_stat_ptr/o_sum/o_mean/o_var                 : token statistics
//   o_err : sticky sequence error
module ln_stage2_reduce
  import ln_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_acc_valid,
  input  logic [PTR_W-1:0]         i_acc_ptr,
  input  logic [CNT_W-1:0]         i_acc_cnt,
  input  logic signed [PSUM_W-1:0] i_part_sum,
  input  logic signed [PSQ_W-1:0]  i_part_sq_sum,
  output logic                     o_stat_valid,
  output logic [PTR_W-1:0]         o_stat_ptr,
  output logic signed [SUM_W-1:0]  o_sum,
  output logic signed [MEAN_W-1:0] o_mean,
  output logic [VAR_W-1:0]         o_var,
  output logic                     o_err
);

  logic signed [SUM_W-1:0] r_acc_sum [N_BANKS];
  logic signed [SQ_W-1:0]  r_acc_sq  [N_BANKS];
  logic [CNT_W-1:0]        r_exp_cnt [N_BANKS];
  logic                    r_bad     [N_BANKS];
  logic                    r_err;

  // Completed token handed to the finalize pipe on the accepting edge.
  logic                    r_fin_valid;
  logic [PTR_W-1:0]        r_fin_ptr;
  logic signed [SUM_W-1:0] r_fin_sum;
  logic signed [SQ_W-1:0]  r_fin_sq;

  logic signed [SUM_W-1:0] w_sum_ext;
  logic signed [SQ_W-1:0]  w_sq_ext;
  logic signed [SUM_W-1:0] w_new_sum;
  logic signed [SQ_W-1:0]  w_new_sq;
  logic                    w_cnt_ok;
  logic                    w_is_last;
  logic                    w_fin_valid;
  stat_t                   w_stat;

  assign w_sum_ext = SUM_W'(i_part_sum);
  assign w_sq_ext  = SQ_W'(i_part_sq_sum);
  assign w_new_sum = r_acc_sum[i_acc_ptr] + w_sum_ext;
  assign w_new_sq  = r_acc_sq[i_acc_ptr] + w_sq_ext;
  assign w_cnt_ok  = (i_acc_cnt < CNT_W'(N_PARTS)) &&
                     (i_acc_cnt == r_exp_cnt[i_acc_ptr]) && !r_bad[i_acc_ptr];
  assign w_is_last = (i_acc_cnt == CNT_W'(N_PARTS - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int b = 0; b < N_BANKS; b++) begin
        r_acc_sum[b] <= '0;
        r_acc_sq[b]  <= '0;
        r_exp_cnt[b] <= '0;
        r_bad[b]     <= 1'b0;
      end
      r_err       <= 1'b0;
      r_fin_valid <= 1'b0;
      r_fin_ptr   <= '0;
      r_fin_sum   <= '0;
      r_fin_sq    <= '0;
    end else if (i_en) begin
      r_fin_valid <= 1'b0;
      if (i_acc_valid) begin
        if (i_acc_cnt == '0) begin
          // restart point for the bank, whatever state it was in
          r_acc_sum[i_acc_ptr] <= w_sum_ext;
          r_acc_sq[i_acc_ptr]  <= w_sq_ext;
          r_exp_cnt[i_acc_ptr] <= CNT_W'(1);
          r_bad[i_acc_ptr]     <= 1'b0;
        end else if (w_cnt_ok) begin
          r_acc_sum[i_acc_ptr] <= w_new_sum;
          r_acc_sq[i_acc_ptr]  <= w_new_sq;
          if (w_is_last) begin
            r_exp_cnt[i_acc_ptr] <= '0;
            r_fin_valid          <= 1'b1;
            r_fin_ptr            <= i_acc_ptr;
            r_fin_sum            <= w_new_sum;
            r_fin_sq             <= w_new_sq;
          end else begin
            r_exp_cnt[i_acc_ptr] <= r_exp_cnt[i_acc_ptr] + CNT_W'(1);
          end
        end else begin
          r_bad[i_acc_ptr] <= 1'b1;
          r_err            <= 1'b1;
        end
      end
    end
  end

  ln_stage2_finalize u_finalize (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (i_en),
    .i_valid (r_fin_valid),
    .i_ptr   (r_fin_ptr),
    .i_sum   (r_fin_sum),
    .i_sq    (r_fin_sq),
    .o_valid (w_fin_valid),
    .o_stat  (w_stat)
  );

  assign o_stat_valid = w_fin_valid;
  assign o_stat_ptr   = w_stat.ptr;
  assign o_sum        = w_stat.sum;
  assign o_mean       = w_stat.mean;
  assign o_var        = w_stat.variance;
  assign o_err        = r_err;

endmodule

// File: tb/tb_ln_stage2_reduce.sv
module tb_ln_stage2_reduce;
  import ln_pkg::*;

  logic                     i_clk = 1'b0;
  logic                     i_rst;
  logic                     i_en;
  logic                     i_acc_valid;
  logic [PTR_W-1:0]         i_acc_ptr;
  logic [CNT_W-1:0]         i_acc_cnt;
  logic signed [PSUM_W-1:0] i_part_sum;
  logic signed [PSQ_W-1:0]  i_part_sq_sum;
  logic                     o_stat_valid;
  logic [PTR_W-1:0]         o_stat_ptr;
  logic signed [SUM_W-1:0]  o_sum;
  logic signed [MEAN_W-1:0] o_mean;
  logic [VAR_W-1:0]         o_var;
  logic                     o_err;

  ln_stage2_reduce dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_en          (i_en),
    .i_acc_valid   (i_acc_valid),
    .i_acc_ptr     (i_acc_ptr),
    .i_acc_cnt     (i_acc_cnt),
    .i_part_sum    (i_part_sum),
    .i_part_sq_sum (i_part_sq_sum),
    .o_stat_valid  (o_stat_valid),
    .o_stat_ptr    (o_stat_ptr),
    .o_sum         (o_sum),
    .o_mean        (o_mean),
    .o_var         (o_var),
    .o_err         (o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int     ptr;
    longint sum;
    longint mean;
    longint vr;
    int     cyc;
  } res_t;

  localparam longint K = 5592406;

  res_t exp_q[$];
  res_t obs_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // A pulse is retired by the next edge only if that edge is enabled.
  always @(negedge i_clk) begin
    if (i_rst && i_en && o_stat_valid) begin
      res_t r;
      r.ptr  = int'(o_stat_ptr);
      r.sum  = longint'(o_sum);
      r.mean = longint'(o_mean);
      r.vr   = longint'(o_var);
      r.cyc  = cyc;
      obs_q.push_back(r);
    end
  end

  // Token-level reference: statistics from the total sum and square sum.
  function automatic res_t model(int ptr, longint s, longint q);
    res_t   r;
    longint mag, m, ex2, msq, v;
    mag = (s < 0) ? -s : s;
    m   = (mag * K) >> 24;
    if (s < 0) m = -m;
    ex2 = (q * K) >>> 24;
    msq = (m * m) >>> 8;
    v   = ex2 - msq;
    if (v < 0) v = 0;
    r.ptr = ptr; r.sum = s; r.mean = m; r.vr = v; r.cyc = 0;
    return r;
  endfunction

  function automatic res_t fixed(int ptr, longint s, longint m, longint v);
    res_t r;
    r.ptr = ptr; r.sum = s; r.mean = m; r.vr = v; r.cyc = 0;
    return r;
  endfunction

  task automatic beat(int p, int c, longint ps, longint pq);
    i_acc_valid   = 1'b1;
    i_acc_ptr     = PTR_W'(p);
    i_acc_cnt     = CNT_W'(c);
    i_part_sum    = PSUM_W'(ps);
    i_part_sq_sum = PSQ_W'(pq);
    @(posedge i_clk); #1;
    i_acc_valid   = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic test_reset;
    i_rst = 1'b0; i_en = 1'b1; i_acc_valid = 1'b1;
    i_acc_ptr = 2'd1; i_acc_cnt = 4'd0; i_part_sum = 22'h12345; i_part_sq_sum = 38'h1234;
    idle(3);
    i_acc_valid = 1'b0;
    n_checks++;
    if (o_stat_valid !== 1'b0 || o_stat_ptr !== '0 || o_sum !== '0 ||
        o_mean !== '0 || o_var !== '0 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b p=%0d s=%0d m=%0d var=%0d err=%b, want all 0",
               o_stat_valid, o_stat_ptr, o_sum, o_mean, o_var, o_err);
    end
    i_rst = 1'b1;
    idle(2);
  endtask

  task automatic test_stage1_pattern;
    obs_q.delete();
    for (int k = 0; k < 12; k++) beat(0, k, 64 * k, 64 * k * k);
    idle(8);
    n_checks++;
    if (obs_q.size() !== 1) begin
      n_fail++; $display("FAIL s1_pulse_count: got %0d want 1", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0].ptr !== 0 || obs_q[0].sum !== 4224 || obs_q[0].mean !== 1408 || obs_q[0].vr !== 3050) begin
        n_fail++;
        $display("FAIL s1_values: got p=%0d s=%0d m=%0d v=%0d want 0/4224/1408/3050",
                 obs_q[0].ptr, obs_q[0].sum, obs_q[0].mean, obs_q[0].vr);
      end
    end
    n_checks++;
    if (o_err !== 1'b0) begin n_fail++; $display("FAIL s1_err: got %b want 0", o_err); end
  endtask

  task automatic test_const;
    obs_q.delete(); exp_q.delete();
    for (int k = 0; k < 12; k++) beat(1, k, 320, 1600);
    exp_q.push_back(fixed(1, 3840, 1280, 0));
    idle(6);
    for (int k = 0; k < 12; k++) beat(3, k, -192, 576);
    exp_q.push_back(fixed(3, -2304, -768, 0));
    idle(8);
    n_checks++;
    if (obs_q.size() !== 2) begin
      n_fail++; $display("FAIL const_pulse_count: got %0d want 2", obs_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs_q[i].ptr !== exp_q[i].ptr || obs_q[i].sum !== exp_q[i].sum ||
            obs_q[i].mean !== exp_q[i].mean || obs_q[i].vr !== exp_q[i].vr) begin
          n_fail++;
          $display("FAIL const_values[%0d]: got p=%0d s=%0d m=%0d v=%0d want p=%0d s=%0d m=%0d v=%0d", i,
                   obs_q[i].ptr, obs_q[i].sum, obs_q[i].mean, obs_q[i].vr,
                   exp_q[i].ptr, exp_q[i].sum, exp_q[i].mean, exp_q[i].vr);
        end
      end
    end
  endtask

  task automatic test_interleave;
    obs_q.delete(); exp_q.delete();
    for (int k = 0; k < 12; k++) begin
      beat(0, k, 64 * k, 64 * k * k);
      beat(1, k, 320, 1600);
    end
    exp_q.push_back(fixed(0, 4224, 1408, 3050));
    exp_q.push_back(fixed(1, 3840, 1280, 0));
    idle(8);
    n_checks++;
    if (obs_q.size() !== 2) begin
      n_fail++; $display("FAIL ilv_pulse_count: got %0d want 2", obs_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (obs_q[i].ptr !== exp_q[i].ptr || obs_q[i].sum !== exp_q[i].sum ||
            obs_q[i].mean !== exp_q[i].mean || obs_q[i].vr !== exp_q[i].vr) begin
          n_fail++;
          $display("FAIL ilv_values[%0d]: got p=%0d s=%0d m=%0d v=%0d want p=%0d s=%0d m=%0d v=%0d", i,
                   obs_q[i].ptr, obs_q[i].sum, obs_q[i].mean, obs_q[i].vr,
                   exp_q[i].ptr, exp_q[i].sum, exp_q[i].mean, exp_q[i].vr);
        end
      end
      n_checks++;
      if (obs_q[1].cyc !== obs_q[0].cyc + 1) begin
        n_fail++; $display("FAIL ilv_consecutive: got gap %0d want 1", obs_q[1].cyc - obs_q[0].cyc);
      end
    end
  endtask

  task automatic test_stall;
    obs_q.delete();
    for (int k = 0; k < 12; k++) beat(3, k, 64 * k, 64 * k * k);
    idle(2);
    n_checks++;
    if (o_stat_valid !== 1'b0) begin n_fail++; $display("FAIL stall_early2: got %b want 0", o_stat_valid); end
    i_en = 1'b0;
    idle(3);
    n_checks++;
    if (o_stat_valid !== 1'b0) begin n_fail++; $display("FAIL stall_frozen: got %b want 0", o_stat_valid); end
    i_en = 1'b1;
    idle(1);
    n_checks++;
    if (o_stat_valid !== 1'b0) begin n_fail++; $display("FAIL stall_early3: got %b want 0", o_stat_valid); end
    idle(1);
    n_checks++;
    if (o_stat_valid !== 1'b1 || o_stat_ptr !== 2'd3 || o_sum !== 26'sd4224 ||
        o_mean !== 24'sd1408 || o_var !== 40'd3050) begin
      n_fail++;
      $display("FAIL stall_result: got v=%b p=%0d s=%0d m=%0d var=%0d want 1/3/4224/1408/3050",
               o_stat_valid, o_stat_ptr, o_sum, o_mean, o_var);
    end
    i_en = 1'b0;
    idle(2);
    n_checks++;
    if (o_stat_valid !== 1'b1 || o_sum !== 26'sd4224) begin
      n_fail++; $display("FAIL stall_pulse_hold: got v=%b s=%0d want 1/4224", o_stat_valid, o_sum);
    end
    i_en = 1'b1;
    idle(1);
    n_checks++;
    if (o_stat_valid !== 1'b0 || o_sum !== 26'sd4224 || o_var !== 40'd3050) begin
      n_fail++; $display("FAIL stall_retire: got v=%b s=%0d var=%0d want 0/4224/3050", o_stat_valid, o_sum, o_var);
    end
    n_checks++;
    if (obs_q.size() !== 1) begin n_fail++; $display("FAIL stall_count: got %0d want 1", obs_q.size()); end
  endtask

  task automatic test_random;
    longint ps [4][12];
    longint pq [4][12];
    longint ts [4];
    longint tq [4];
    int     nxt [4];
    int     pending, b, guard;
    logic   v;
    obs_q.delete(); exp_q.delete();
    for (int round = 0; round < 4; round++) begin
      for (int bb = 0; bb < 4; bb++) begin
        ts[bb] = 0; tq[bb] = 0; nxt[bb] = 0;
        for (int k = 0; k < 12; k++) begin
          ps[bb][k] = longint'($urandom_range(0, 2097151)) - 1048576;
          pq[bb][k] = longint'($urandom_range(0, 1073741824));
          ts[bb] += ps[bb][k];
          tq[bb] += pq[bb][k];
        end
      end
      pending = 48; guard = 0;
      while (pending > 0 && guard < 2000) begin
        guard++;
        do b = int'($urandom_range(0, 3)); while (nxt[b] >= 12);
        v = ($urandom_range(0, 3) != 0);
        i_en          = ($urandom_range(0, 4) != 0);
        i_acc_valid   = v;
        i_acc_ptr     = PTR_W'(b);
        i_acc_cnt     = CNT_W'(nxt[b]);
        i_part_sum    = PSUM_W'(ps[b][nxt[b]]);
        i_part_sq_sum = PSQ_W'(pq[b][nxt[b]]);
        @(posedge i_clk); #1;
        if (i_en && v) begin
          if (nxt[b] == 11) exp_q.push_back(model(b, ts[b], tq[b]));
          nxt[b]++;
          pending--;
        end
      end
      i_acc_valid = 1'b0;
      i_en = 1'b1;
      n_checks++;
      if (pending !== 0) begin n_fail++; $display("FAIL rnd_timeout: got %0d beats left want 0", pending); end
    end
    idle(8);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL rnd_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (obs_q[i].ptr !== exp_q[i].ptr || obs_q[i].sum !== exp_q[i].sum ||
            obs_q[i].mean !== exp_q[i].mean || obs_q[i].vr !== exp_q[i].vr) begin
          n_fail++;
          $display("FAIL rnd_values[%0d]: got p=%0d s=%0d m=%0d v=%0d want p=%0d s=%0d m=%0d v=%0d", i,
                   obs_q[i].ptr, obs_q[i].sum, obs_q[i].mean, obs_q[i].vr,
                   exp_q[i].ptr, exp_q[i].sum, exp_q[i].mean, exp_q[i].vr);
        end
      end
    end
    n_checks++;
    if (o_err !== 1'b0) begin n_fail++; $display("FAIL rnd_err: got %b want 0", o_err); end
  endtask

  task automatic test_seq_error;
    obs_q.delete();
    for (int k = 0; k < 12; k++) if (k != 3) beat(2, k, 320, 1600);
    idle(8);
    n_checks++;
    if (o_err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", o_err); end
    n_checks++;
    if (obs_q.size() !== 0) begin n_fail++; $display("FAIL err_no_pulse: got %0d want 0", obs_q.size()); end
    for (int k = 0; k < 12; k++) beat(2, k, 64 * k, 64 * k * k);
    idle(8);
    n_checks++;
    if (obs_q.size() !== 1) begin
      n_fail++; $display("FAIL err_rearm_count: got %0d want 1", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0].ptr !== 2 || obs_q[0].sum !== 4224 || obs_q[0].mean !== 1408 || obs_q[0].vr !== 3050) begin
        n_fail++;
        $display("FAIL err_rearm_values: got p=%0d s=%0d m=%0d v=%0d want 2/4224/1408/3050",
                 obs_q[0].ptr, obs_q[0].sum, obs_q[0].mean, obs_q[0].vr);
      end
    end
    n_checks++;
    if (o_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", o_err); end
  endtask

  task automatic test_reset_mid;
    obs_q.delete();
    for (int k = 0; k < 6; k++) beat(1, k, 320, 1600);
    for (int k = 0; k < 12; k++) beat(0, k, -192, 576);
    i_rst = 1'b0;
    idle(1);
    i_rst = 1'b1;
    n_checks++;
    if (o_stat_valid !== 1'b0 || o_stat_ptr !== '0 || o_sum !== '0 ||
        o_mean !== '0 || o_var !== '0 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got v=%b p=%0d s=%0d m=%0d var=%0d err=%b want all 0",
               o_stat_valid, o_stat_ptr, o_sum, o_mean, o_var, o_err);
    end
    for (int k = 6; k < 12; k++) beat(1, k, 320, 1600);
    idle(8);
    n_checks++;
    if (obs_q.size() !== 0) begin n_fail++; $display("FAIL rstmid_no_pulse: got %0d want 0", obs_q.size()); end
    n_checks++;
    if (o_err !== 1'b1) begin n_fail++; $display("FAIL rstmid_err: got %b want 1", o_err); end
  endtask

  initial begin
    i_rst = 1'b0; i_en = 1'b1; i_acc_valid = 1'b0;
    i_acc_ptr = '0; i_acc_cnt = '0; i_part_sum = '0; i_part_sq_sum = '0;
    #1;
    test_reset;
    test_stage1_pattern;
    test_const;
    test_interleave;
    test_stall;
    test_random;
    test_seq_error;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
